pe_seq_ctrl: RTL

- Sequencer for the parallel_pe datapath.
- Walks a small instruction table; each entry is the number of 512-bit neuron/weight beats to accumulate for one output.
- Generates neuron/weight read addresses, vld_i and ctl[1:0] (first/last beat) for the PE.
- Captures each PE result into a result-write port and reports completion.
- Sits between the instruction/neuron/weight buffers and the PE, replacing testbench-driven sequencing.

---
 rtl/pe_seq_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pe_seq_ctrl.sv
// Sequencer that walks an instruction table and issues PE beats and result writes.
// Latency: FETCH 1 cycle, then one beat per non-held cycle; results are written in the cycle they arrive.
// Backpressure: hold freezes beat issue in RUN; PE results can never be stalled.
module pe_seq_ctrl #(
  parameter int INST_NUM = 4,
  parameter int INST_AW  = 2,
  parameter int ADDR_W   = 16,
  parameter int INST_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
  output logic [INST_AW-1:0] inst_addr,
  input  logic [INST_W-1:0]  inst_data,
  output logic [ADDR_W-1:0]  neuron_addr,
  output logic [ADDR_W-1:0]  weight_addr,
  output logic [1:0]         pe_ctl,
  output logic               pe_vld_i,
  input  logic               pe_vld_o,
  input  logic [31:0]        pe_result,
  output logic               res_we,
  output logic [INST_AW-1:0] res_addr,
  output logic [31:0]        res_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [INST_AW-1:0] LAST_IDX = INST_AW'(INST_NUM - 1);

  state_t              state_q, state_d;
  logic [INST_AW-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INST_W-1:0]   cnt_q, cnt_d;
  logic [INST_W-1:0]   iter_q, iter_d;
  logic [INST_AW:0]    issued_q, issued_d;
  logic [INST_AW:0]    rcnt_q, rcnt_d;
  logic                err_q, err_d;

  logic                beat;
  logic                first_iter;
  logic                last_iter;
  logic                res_fault;

  // Beat qualification and protocol-fault detection.
  always_comb begin
    beat       = (state_q == S_RUN) && !hold;
    first_iter = (iter_q == '0);
    last_iter  = (iter_q == (cnt_q - INST_W'(1)));
    // A result in IDLE, or one beyond the number of issued instructions, is a fault.
    res_fault  = pe_vld_o && ((state_q == S_IDLE) || (rcnt_q == issued_q));
  end

  // Next-state logic for the sequencer and its counters.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    iter_d   = iter_q;
    issued_d = issued_q;
    rcnt_d   = rcnt_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        idx_d    = '0;
        addr_d   = '0;
        cnt_d    = '0;
        iter_d   = '0;
        issued_d = '0;
        rcnt_d   = '0;
        if (start) begin
          state_d = S_FETCH;
          err_d   = 1'b0;
        end
      end
      S_FETCH: begin
        cnt_d  = inst_data;
        iter_d = '0;
        if (inst_data != '0) begin
          state_d  = S_RUN;
          issued_d = issued_q + (INST_AW+1)'(1);
        end else if (idx_q == LAST_IDX) begin
          // Zero-length entries produce no result and no beats.
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + INST_AW'(1);
        end
      end
      S_RUN: begin
        if (beat) begin
          addr_d = addr_q + ADDR_W'(1);
          iter_d = iter_q + INST_W'(1);
          if (last_iter) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DRAIN;
            end else begin
              idx_d   = idx_q + INST_AW'(1);
              state_d = S_FETCH;
            end
          end
        end
      end
      S_DRAIN: begin
        if (rcnt_q == issued_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results are counted in every active state; IDLE keeps the count cleared.
    if (pe_vld_o && (state_q != S_IDLE)) begin
      rcnt_d = rcnt_q + (INST_AW+1)'(1);
    end
    if (res_fault) begin
      err_d = 1'b1;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      iter_q   <= '0;
      issued_q <= '0;
      rcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      iter_q   <= iter_d;
      issued_q <= issued_d;
      rcnt_q   <= rcnt_d;
      err_q    <= err_d;
    end
  end

  // Output decode; result capture is a zero-latency pass-through.
  always_comb begin
    inst_addr   = idx_q;
    neuron_addr = addr_q;
    weight_addr = addr_q;
    pe_vld_i    = beat;
    pe_ctl      = (state_q == S_RUN) ? {last_iter, first_iter} : 2'b00;
    res_we      = pe_vld_o;
    res_addr    = rcnt_q[INST_AW-1:0];
    res_data    = pe_result;
    busy        = (state_q == S_FETCH) || (state_q == S_RUN) || (state_q == S_DRAIN);
    done        = (state_q == S_DONE);
    err         = err_q;
  end

endmodule
